// File: rtl/blink_rate_decoder_pkg.sv
// Shared constants for the switch-selected LED blink scheme.
// The transmitter and this decoder both derive their half-periods from half_period().
package blink_rate_decoder_pkg;

  localparam logic [1:0] RATE_1HZ  = 2'd0;
  localparam logic [1:0] RATE_10HZ = 2'd1;
  localparam logic [1:0] RATE_20HZ = 2'd2;
  localparam logic [1:0] RATE_30HZ = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACQUIRE = ST_ACQUIRE,
    LOCKED  = ST_LOCKED
  } state_t;

  function automatic int unsigned rate_hz(input logic [1:0] code);
    case (code)
      RATE_1HZ:  return 1;
      RATE_10HZ: return 10;
      RATE_20HZ: return 20;
      default:   return 30;
    endcase
  endfunction

  // The +1 accounts for a transmitter counter that runs 0..N inclusive.
  function automatic int unsigned half_period(input int unsigned clock_frequency,
                                              input logic [1:0]  code);
    return clock_frequency / (2 * rate_hz(code)) + 1;
  endfunction

  function automatic int unsigned tolerance(input int unsigned n);
    return n >> 3;
  endfunction

endpackage

// File: rtl/blink_rate_decoder_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop that
// turns any level change into a one-cycle pulse.
module sync_edge_detect
  import blink_rate_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic edge_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign edge_pulse = sync_p1 ^ sync_p2;

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures half-periods of the incoming blink square wave, recovers the
// 2-bit rate code after LOCK_COUNT consistent periods, and flags loss of signal.
module blink_rate_decoder
  import blink_rate_decoder_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 66000000,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blink_in,
  output logic [1:0] rate_code,
  output logic       code_valid,
  output logic       lock_pulse,
  output logic       no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT =
    CNT_W'(2 * half_period(CLOCK_FREQUENCY, RATE_1HZ));

  localparam logic [3:0][CNT_W-1:0] N_TAB = {
    CNT_W'(half_period(CLOCK_FREQUENCY, RATE_30HZ)),
    CNT_W'(half_period(CLOCK_FREQUENCY, RATE_20HZ)),
    CNT_W'(half_period(CLOCK_FREQUENCY, RATE_10HZ)),
    CNT_W'(half_period(CLOCK_FREQUENCY, RATE_1HZ))
  };

  localparam logic [3:0][CNT_W-1:0] TOL_TAB = {
    CNT_W'(tolerance(half_period(CLOCK_FREQUENCY, RATE_30HZ))),
    CNT_W'(tolerance(half_period(CLOCK_FREQUENCY, RATE_20HZ))),
    CNT_W'(tolerance(half_period(CLOCK_FREQUENCY, RATE_10HZ))),
    CNT_W'(tolerance(half_period(CLOCK_FREQUENCY, RATE_1HZ)))
  };

  localparam logic [3:0] LOCK_MATCH = 4'(LOCK_COUNT);

  function automatic logic in_window(input logic [CNT_W-1:0] m,
                                     input logic [CNT_W-1:0] n,
                                     input logic [CNT_W-1:0] tol);
    logic [CNT_W-1:0] diff;
    diff = (m > n) ? (m - n) : (n - m);
    return diff <= tol;
  endfunction

  logic             edge_pulse;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] meas;
  logic             cls_valid;
  logic [1:0]       cls_code;
  logic [3:0]       match_cnt;
  logic [3:0]       next_match;
  logic [1:0]       cand;
  logic             timeout;
  state_t           state;

  // Stage p0..p2: pin synchronisation and edge extraction
  sync_edge_detect u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (blink_in),
    .edge_pulse (edge_pulse)
  );

  // Stage p3: half-period measurement; the counter restarts on the edge it measures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= '0;
    end else if (cnt != TIMEOUT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign meas    = cnt + CNT_W'(1);
  assign timeout = !edge_pulse && (cnt == TIMEOUT - CNT_W'(1));

  always_comb begin
    cls_valid = 1'b0;
    cls_code  = RATE_1HZ;
    for (int k = 0; k < 4; k++) begin
      if (in_window(meas, N_TAB[k], TOL_TAB[k])) begin
        cls_valid = 1'b1;
        cls_code  = 2'(k);
      end
    end
  end

  always_comb begin
    next_match = {3'b000, cls_valid};
    if (cls_valid && (cls_code == cand)) begin
      next_match = match_cnt + 4'd1;
    end
  end

  // Stage p4: lock state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= RATE_1HZ;
      match_cnt  <= '0;
      rate_code  <= RATE_1HZ;
      code_valid <= 1'b0;
      lock_pulse <= 1'b0;
      no_signal  <= 1'b1;
    end else begin
      lock_pulse <= 1'b0;
      if (edge_pulse) begin
        case (state)
          IDLE: begin
            state     <= ACQUIRE;
            match_cnt <= '0;
            no_signal <= 1'b0;
          end
          ACQUIRE: begin
            match_cnt <= next_match;
            if (cls_valid) begin
              cand <= cls_code;
            end
            if (cls_valid && (next_match == LOCK_MATCH)) begin
              state      <= LOCKED;
              rate_code  <= cls_code;
              code_valid <= 1'b1;
              lock_pulse <= 1'b1;
            end
          end
          LOCKED: begin
            if (!(cls_valid && (cls_code == rate_code))) begin
              state      <= ACQUIRE;
              code_valid <= 1'b0;
              match_cnt  <= {3'b000, cls_valid};
              if (cls_valid) begin
                cand <= cls_code;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end else if (timeout) begin
        state      <= IDLE;
        no_signal  <= 1'b1;
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder at CLOCK_FREQUENCY = 6600: expected lock
// events are queued as edges are driven and matched against lock_pulse.
module tb_blink_rate_decoder;

  localparam int unsigned CF      = 6600;
  localparam int unsigned LC      = 4;
  localparam int unsigned CW      = 27;
  localparam int          TIMEOUT = 6602;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       blink_in = 1'b0;
  logic [1:0] rate_code;
  logic       code_valid;
  logic       lock_pulse;
  logic       no_signal;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int last_tog = 0;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } lock_exp_t;

  lock_exp_t exp_q[$];
  lock_exp_t got_e;

  blink_rate_decoder #(
    .CLOCK_FREQUENCY (CF),
    .LOCK_COUNT      (LC),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blink_in   (blink_in),
    .rate_code  (rate_code),
    .code_valid (code_valid),
    .lock_pulse (lock_pulse),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every lock_pulse must match the oldest queued lock expectation
  always @(negedge clk) begin
    if (lock_pulse === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL lock_unexpected at cycle %0d rate_code %0d, no lock was due", cyc, rate_code);
      end
      if (exp_q.size() != 0) begin
        got_e = exp_q.pop_front();
        tests += 2;
        assert (cyc === got_e.cyc) else begin
          fails++;
          $error("FAIL lock_cycle got %0d want %0d", cyc, got_e.cyc);
        end
        assert (rate_code === got_e.code) else begin
          fails++;
          $error("FAIL lock_code got %0d want %0d", rate_code, got_e.code);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (last_tog + n - cyc) @(posedge clk);
    #1 blink_in = ~blink_in;
    last_tog = cyc;
  endtask

  task automatic expect_lock(input logic [1:0] code);
    lock_exp_t e;
    e.cyc  = cyc + 3;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic v, input logic [1:0] c, input logic ns);
    tests += 3;
    assert (code_valid === v) else begin
      fails++;
      $error("FAIL %s code_valid got %b want %b", tag, code_valid, v);
    end
    assert (rate_code === c) else begin
      fails++;
      $error("FAIL %s rate_code got %0d want %0d", tag, rate_code, c);
    end
    assert (no_signal === ns) else begin
      fails++;
      $error("FAIL %s no_signal got %b want %b", tag, no_signal, ns);
    end
  endtask

  task automatic check_pulse_low(input string tag);
    tests++;
    assert (lock_pulse === 1'b0) else begin
      fails++;
      $error("FAIL %s lock_pulse got %b want 0", tag, lock_pulse);
    end
  endtask

  initial begin
    wait_cyc(3);
    check("reset", 1'b0, 2'd0, 1'b1);
    check_pulse_low("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_tog = cyc;

    // 30 Hz from reset: first edge only leaves IDLE, lock on the fifth
    for (int i = 0; i < 4; i++) hold(111);
    wait_cyc(5);
    check("t1_prelock", 1'b0, 2'd0, 1'b0);
    hold(111);
    expect_lock(2'd3);
    wait_cyc(5);
    check("t1_locked", 1'b1, 2'd3, 1'b0);

    // 10 Hz, then switch to 20 Hz
    for (int i = 0; i < 4; i++) begin
      hold(331);
      if (i == 3) expect_lock(2'd1);
    end
    wait_cyc(5);
    check("t2_lock10", 1'b1, 2'd1, 1'b0);
    hold(166);
    wait_cyc(3);
    check("t2_hold", 1'b1, 2'd1, 1'b0);
    wait_cyc(1);
    check("t2_drop", 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      hold(166);
      if (i == 2) expect_lock(2'd2);
    end
    wait_cyc(5);
    check("t2_lock20", 1'b1, 2'd2, 1'b0);

    // Out-of-window period never locks; 372 is the top of the 10 Hz window, 373 is outside
    for (int i = 0; i < 6; i++) hold(250);
    wait_cyc(5);
    check("t3_invalid", 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hold(372);
      if (i == 3) expect_lock(2'd1);
    end
    wait_cyc(5);
    check("t3_edge_hi", 1'b1, 2'd1, 1'b0);
    hold(373);
    wait_cyc(5);
    check("t3_out_hi", 1'b0, 2'd1, 1'b0);

    // 1 Hz lock, then a constant pin times out exactly TIMEOUT cycles after the last edge
    for (int i = 0; i < 4; i++) begin
      hold(3301);
      if (i == 3) expect_lock(2'd0);
    end
    wait_cyc(TIMEOUT + 3);
    check("t4_pre_timeout", 1'b1, 2'd0, 1'b0);
    wait_cyc(1);
    check("t4_timeout", 1'b0, 2'd0, 1'b1);

    // Reset mid-lock at an arbitrary phase
    last_tog = cyc;
    for (int i = 0; i < 5; i++) begin
      hold(111);
      if (i == 4) expect_lock(2'd3);
    end
    wait_cyc(40);
    rst_n = 1'b0;
    #1;
    check("t5_reset", 1'b0, 2'd0, 1'b1);
    check_pulse_low("t5_reset");
    blink_in = 1'b0;
    wait_cyc(3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_tog = cyc;
    for (int i = 0; i < 4; i++) hold(111);
    wait_cyc(5);
    check("t5_prelock", 1'b0, 2'd0, 1'b0);
    hold(111);
    expect_lock(2'd3);
    wait_cyc(5);
    check("t5_relock", 1'b1, 2'd3, 1'b0);

    // Jitter within +/-13 keeps 30 Hz; a 200-cycle glitch drops lock
    hold(250);
    hold(111);
    hold(110);
    hold(112);
    hold(111);
    expect_lock(2'd3);
    wait_cyc(5);
    check("t6_jitter_lock", 1'b1, 2'd3, 1'b0);
    hold(98);
    hold(124);
    wait_cyc(5);
    check("t6_tol_edges", 1'b1, 2'd3, 1'b0);
    hold(200);
    wait_cyc(5);
    check("t6_glitch", 1'b0, 2'd3, 1'b0);

    wait_cyc(5);
    tests++;
    assert (exp_q.size() === 0) else begin
      fails++;
      $error("FAIL lock_missing got %0d pending locks want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
